// File: rtl/etc_vehicle_emulator_pkg.sv
// Shared types for the toll-lane vehicle emulator: FSM state encoding and ms timing helper.
package etc_vehicle_emulator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_S1_ON = 3'd1,
        ST_GAP1  = 3'd2,
        ST_S2_ON = 3'd3,
        ST_GAP2  = 3'd4,
        ST_S3_ON = 3'd5
    } state_e;

    function automatic int ticks_per_ms(input int sys_freq);
        return sys_freq / 1000;
    endfunction

endpackage

// File: rtl/etc_ms_tick.sv
// Intra-millisecond tick counter; ms_tick is high on the last tick of each ms.
module etc_ms_tick #(
    parameter int TICKS     = 50000,
    parameter int WIDTH_TIK = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic ms_tick
);

    localparam logic [WIDTH_TIK-1:0] LAST_TICK = WIDTH_TIK'(TICKS - 1);

    logic [WIDTH_TIK-1:0] tick_q;
    logic [WIDTH_TIK-1:0] tick_d;

    always_comb begin
        tick_d = tick_q + WIDTH_TIK'(1);
        if (clear || tick_q == LAST_TICK) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign ms_tick = (tick_q == LAST_TICK);

endmodule

// File: rtl/etc_vehicle_emulator.sv
// Replays one vehicle pass on the three lane sensors with ms-exact rising-edge spacing.
module etc_vehicle_emulator
    import etc_vehicle_emulator_pkg::*;
#(
    parameter int SYS_FREQ  = 50000000,
    parameter int WIDTH_TIK = 16,
    parameter int WIDTH_MS  = 9,
    parameter int PULSE_MS  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [WIDTH_MS-1:0] gap_ms,
    input  logic                epass_ok,
    output logic                sensor1,
    output logic                sensor2,
    output logic                sensor3,
    output logic                valid_Epass,
    output logic                busy,
    output logic                pass_done
);

    localparam int TICKS = ticks_per_ms(SYS_FREQ);
    localparam int LW    = WIDTH_MS + 1;
    localparam logic [LW-1:0] PULSE_LEN = LW'(PULSE_MS);
    localparam logic [LW-1:0] MIN_GAP   = LW'(PULSE_MS + 1);

    state_e              state_q, state_d;
    logic [WIDTH_MS-1:0] ms_q, ms_d;
    logic [WIDTH_MS-1:0] gap_q, gap_d;
    logic                ep_q, ep_d;
    logic                pend_q, pend_d;
    logic                sensor1_q, sensor1_d;
    logic                sensor2_q, sensor2_d;
    logic                sensor3_q, sensor3_d;
    logic                valid_epass_q, valid_epass_d;
    logic                busy_q, busy_d;
    logic                pass_done_q, pass_done_d;

    logic                ms_tick;
    logic                tick_clear;
    logic [LW-1:0]       gap_ext;
    logic [LW-1:0]       eff_gap;
    logic [LW-1:0]       phase_len;
    logic [LW-1:0]       last_ms;
    logic                phase_end;
    logic                finish;
    logic                accept;

    etc_ms_tick #(
        .TICKS     (TICKS),
        .WIDTH_TIK (WIDTH_TIK)
    ) u_ms_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (tick_clear),
        .ms_tick (ms_tick)
    );

    always_comb begin
        gap_ext   = {1'b0, gap_q};
        eff_gap   = (gap_ext < MIN_GAP) ? MIN_GAP : gap_ext;
        // Extended width keeps eff_gap - PULSE_LEN from wrapping.
        phase_len = (state_q == ST_GAP1 || state_q == ST_GAP2) ? (eff_gap - PULSE_LEN) : PULSE_LEN;
        last_ms   = phase_len - LW'(1);
        phase_end = (state_q != ST_IDLE) && ms_tick && ({1'b0, ms_q} == last_ms);
        finish    = (state_q == ST_S3_ON) && phase_end;
        // A pass ending on this edge frees the emulator for a back-to-back start.
        accept    = start && ((state_q == ST_IDLE && !pend_q) || finish);

        state_d = state_q;
        gap_d   = gap_q;
        ep_d    = ep_q;
        pend_d  = 1'b0;

        if (pend_q) begin
            state_d = ST_S1_ON;
        end else if (phase_end) begin
            case (state_q)
                ST_S1_ON: state_d = ST_GAP1;
                ST_GAP1:  state_d = ST_S2_ON;
                ST_S2_ON: state_d = ST_GAP2;
                ST_GAP2:  state_d = ST_S3_ON;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (accept) begin
            gap_d  = gap_ms;
            ep_d   = epass_ok;
            pend_d = 1'b1;
        end

        tick_clear = (state_d != state_q) || (state_q == ST_IDLE);
        ms_d       = ms_q;
        if (tick_clear) begin
            ms_d = '0;
        end else if (ms_tick) begin
            ms_d = ms_q + WIDTH_MS'(1);
        end

        sensor1_d     = (state_d == ST_S1_ON);
        sensor2_d     = (state_d == ST_S2_ON);
        sensor3_d     = (state_d == ST_S3_ON);
        busy_d        = (state_d != ST_IDLE);
        valid_epass_d = ep_d && (state_d != ST_IDLE);
        pass_done_d   = finish;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ms_q          <= '0;
            gap_q         <= '0;
            ep_q          <= 1'b0;
            pend_q        <= 1'b0;
            sensor1_q     <= 1'b0;
            sensor2_q     <= 1'b0;
            sensor3_q     <= 1'b0;
            valid_epass_q <= 1'b0;
            busy_q        <= 1'b0;
            pass_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ms_q          <= ms_d;
            gap_q         <= gap_d;
            ep_q          <= ep_d;
            pend_q        <= pend_d;
            sensor1_q     <= sensor1_d;
            sensor2_q     <= sensor2_d;
            sensor3_q     <= sensor3_d;
            valid_epass_q <= valid_epass_d;
            busy_q        <= busy_d;
            pass_done_q   <= pass_done_d;
        end
    end

    assign sensor1     = sensor1_q;
    assign sensor2     = sensor2_q;
    assign sensor3     = sensor3_q;
    assign valid_Epass = valid_epass_q;
    assign busy        = busy_q;
    assign pass_done   = pass_done_q;

endmodule

// File: tb/tb_etc_vehicle_emulator.sv
// Scoreboard bench: stimulus queues expected output transitions, a monitor checks every change.
module tb_etc_vehicle_emulator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [8:0] gap_ms;
    logic       epass_ok;
    logic       sensor1, sensor2, sensor3, valid_Epass, busy, pass_done;

    etc_vehicle_emulator #(
        .SYS_FREQ  (10000),
        .WIDTH_TIK (16),
        .WIDTH_MS  (9),
        .PULSE_MS  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .gap_ms      (gap_ms),
        .epass_ok    (epass_ok),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .sensor3     (sensor3),
        .valid_Epass (valid_Epass),
        .busy        (busy),
        .pass_done   (pass_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [5:0] prev_vec = 6'b0;
    logic [5:0] cur_vec;

    assign cur_vec = {sensor1, sensor2, sensor3, valid_Epass, busy, pass_done};

    // Monitor: every change of the output vector must match the next queued event.
    always @(negedge clk) begin
        if (cur_vec !== prev_vec) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b prev=%b (no event queued)", cyc, cur_vec, prev_vec);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.vec !== cur_vec) begin
                    n_bad++;
                    $display("FAIL event got cyc=%0d vec=%b required cyc=%0d vec=%b", cyc, cur_vec, e.cyc, e.vec);
                end else begin
                    $display("ok event cyc=%0d vec=%b", cyc, cur_vec);
                end
            end
            prev_vec = cur_vec;
        end
    end

    task automatic push_ev(input int c, input logic [5:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // Expected transitions of one pass accepted at edge b (T=10 ticks/ms, pulse 20 cycles).
    task automatic push_pass(input int b, input int g, input logic ep, input bit chain);
        int gt;
        gt = ((g < 3) ? 3 : g) * 10;
        push_ev(b + 1,            {3'b100, ep, 2'b10});
        push_ev(b + 21,           {3'b000, ep, 2'b10});
        push_ev(b + 1 + gt,       {3'b010, ep, 2'b10});
        push_ev(b + 21 + gt,      {3'b000, ep, 2'b10});
        push_ev(b + 1 + 2 * gt,   {3'b001, ep, 2'b10});
        push_ev(b + 21 + 2 * gt,  6'b000001);
        if (!chain) push_ev(b + 22 + 2 * gt, 6'b000000);
    endtask

    task automatic issue(input int g, input logic ep, output int b);
        @(negedge clk);
        start    = 1'b1;
        gap_ms   = 9'(g);
        epass_ok = ep;
        b        = cyc + 1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: %0d events still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    int b;

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        gap_ms   = 9'd0;
        epass_ok = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cur_vec !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_state got=%b required=000000", cur_vec);
        end else begin
            $display("ok reset_state vec=%b", cur_vec);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: nominal pass with E-pass
        issue(5, 1'b1, b);
        push_pass(b, 5, 1'b1, 1'b0);
        drain("s1_nominal", 200);

        // 2: gap clamped to PULSE_MS+1
        issue(0, 1'b0, b);
        push_pass(b, 0, 1'b0, 1'b0);
        drain("s2_clamp", 200);

        // 3: start re-pulsed mid-pass is ignored
        issue(5, 1'b1, b);
        push_pass(b, 5, 1'b1, 1'b0);
        wait_until(b + 39);
        start    = 1'b1;
        gap_ms   = 9'd9;
        epass_ok = 1'b0;
        @(negedge clk);
        start = 1'b0;
        drain("s3_ignore", 200);

        // 4: start held high gives back-to-back passes
        @(negedge clk);
        start    = 1'b1;
        gap_ms   = 9'd5;
        epass_ok = 1'b1;
        b        = cyc + 1;
        push_pass(b, 5, 1'b1, 1'b1);
        push_pass(b + 121, 5, 1'b1, 1'b0);
        wait_until(b + 150);
        start = 1'b0;
        drain("s4_back2back", 300);

        // 5: asynchronous reset aborts a pass, then a fresh pass runs
        issue(5, 1'b1, b);
        push_ev(b + 1,  6'b100110);
        push_ev(b + 21, 6'b000110);
        push_ev(b + 51, 6'b010110);
        push_ev(b + 60, 6'b000000);
        wait_until(b + 59);
        @(posedge clk);
        #2 reset_n = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        drain("s5_abort", 20);
        issue(5, 1'b1, b);
        push_pass(b, 5, 1'b1, 1'b0);
        drain("s5_restart", 200);

        // 6: maximum gap
        issue(511, 1'b0, b);
        push_pass(b, 511, 1'b0, 1'b0);
        drain("s6_maxgap", 11000);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_queue got=%0d pending required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
